// File: rtl/crtc_timing.sv
// ---------------------------------------------------------------------------
// crtc_timing
// Video timing sequencer for the PET clone CRTC. It reads the programmed
// values of R0-R9 and R12/R13 from the register file and steps through the
// frame one character time at a time. On each step it produces the sync
// pulses, display enable, and the video RAM address (MA) and scan-line
// address (RA) consumed by the video fetch/shift logic.
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_char_en      one-clock strobe per character time; state advances only here
//   i_h_total      R0, the line is R0+1 characters
//   i_h_displayed  R1, displayed characters per line
//   i_h_sync_pos   R2, character index where HSYNC starts
//   i_sync_width   R3, [3:0] HSYNC width (0 = none), [7:4] VSYNC lines (0 = 16)
//   i_v_total      R4, the frame is R4+1 character rows
//   i_v_adjust     R5, extra scan lines after the last row
//   i_v_displayed  R6, displayed character rows
//   i_v_sync_pos   R7, character row where VSYNC starts
//   i_max_scan     R9, each row is R9+1 scan lines
//   i_start_addr   {R12[5:0], R13}, MA at the top of the frame
//   o_h_sync       horizontal sync
//   o_v_sync       vertical sync
//   o_de           display enable
//   o_ma           video memory address
//   o_ra           scan-line address
//   o_frame_start  one-clock pulse on the step that begins a new frame
//
// Every registered output describes the counter position of the previous
// character step, so all of them share one character of latency.
// ---------------------------------------------------------------------------
module crtc_timing (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_char_en,
    input  logic [7:0]  i_h_total,
    input  logic [7:0]  i_h_displayed,
    input  logic [7:0]  i_h_sync_pos,
    input  logic [7:0]  i_sync_width,
    input  logic [6:0]  i_v_total,
    input  logic [4:0]  i_v_adjust,
    input  logic [6:0]  i_v_displayed,
    input  logic [6:0]  i_v_sync_pos,
    input  logic [4:0]  i_max_scan,
    input  logic [13:0] i_start_addr,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_de,
    output logic [13:0] o_ma,
    output logic [4:0]  o_ra,
    output logic        o_frame_start
);

    typedef enum logic {
        ST_ACTIVE,
        ST_ADJUST
    } vstate_t;

    vstate_t     r_state;
    logic [7:0]  r_hc;
    logic [4:0]  r_ra_cnt;
    logic [6:0]  r_vc;
    logic [4:0]  r_adj;
    logic [3:0]  r_hs_cnt;
    logic [4:0]  r_vs_cnt;
    logic [13:0] r_ma_row;
    logic [13:0] r_ma_cnt;

    logic        w_line_end;
    logic        w_ra_last;
    logic        w_last_row;
    logic        w_row_end;
    logic        w_enter_adjust;
    logic        w_frame_start;
    logic        w_hs_start;
    logic        w_hs_now;
    logic [4:0]  w_vs_len;
    logic        w_vs_start;
    logic        w_vs_now;
    logic        w_de_now;
    logic [13:0] w_ma_next_row;

    // Magnitude compares (>=) rather than equality everywhere a counter is
    // checked against a live register, so that lowering a register while the
    // counter is already past it ends the line/row/frame instead of letting
    // the counter run all the way round its range.
    assign w_line_end     = (r_hc >= i_h_total);
    assign w_ra_last      = (r_ra_cnt >= i_max_scan);
    assign w_last_row     = !(r_vc < i_v_total);
    assign w_row_end      = w_line_end && (r_state == ST_ACTIVE) && w_ra_last && !w_last_row;
    assign w_enter_adjust = w_line_end && (r_state == ST_ACTIVE) && w_ra_last && w_last_row
                            && (i_v_adjust != 5'd0);
    assign w_frame_start  = w_line_end &&
                            (((r_state == ST_ACTIVE) && w_ra_last && w_last_row && (i_v_adjust == 5'd0)) ||
                             ((r_state == ST_ADJUST) && (({1'b0, r_adj} + 6'd1) >= {1'b0, i_v_adjust})));

    assign w_ma_next_row  = r_ma_row + {6'd0, i_h_displayed};

    // HSYNC is timed by its own down-counter so a pulse that runs past the end
    // of the line keeps going after hc wraps. A start while the counter is
    // still running is ignored. A start position beyond R0 can only be hit
    // transiently after R0 is lowered, and must not produce a pulse.
    assign w_hs_start = (r_hc == i_h_sync_pos) && (i_h_sync_pos <= i_h_total)
                        && (i_sync_width[3:0] != 4'd0) && (r_hs_cnt == 4'd0);
    assign w_hs_now   = w_hs_start || (r_hs_cnt != 4'd0);

    // VSYNC counts whole lines and survives a frame start. A zero width field
    // means the full 16 lines.
    assign w_vs_len   = (i_sync_width[7:4] == 4'd0) ? 5'd16 : {1'b0, i_sync_width[7:4]};
    assign w_vs_start = (r_state == ST_ACTIVE) && (r_ra_cnt == 5'd0) && (r_hc == 8'd0)
                        && (r_vc == i_v_sync_pos) && (i_v_sync_pos <= i_v_total)
                        && (r_vs_cnt == 5'd0);
    assign w_vs_now   = w_vs_start || (r_vs_cnt != 5'd0);

    assign w_de_now   = (r_hc < i_h_displayed) && (r_state == ST_ACTIVE) && (r_vc < i_v_displayed);

    // Single sequential block: counters, vertical state machine and the
    // registered outputs all advance together on a character step. The
    // frame_start pulse is cleared on every clock so it lasts exactly one
    // clock even when char_en strobes are spaced out.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_ACTIVE;
            r_hc          <= 8'd0;
            r_ra_cnt      <= 5'd0;
            r_vc          <= 7'd0;
            r_adj         <= 5'd0;
            r_hs_cnt      <= 4'd0;
            r_vs_cnt      <= 5'd0;
            r_ma_row      <= 14'd0;
            r_ma_cnt      <= 14'd0;
            o_h_sync      <= 1'b0;
            o_v_sync      <= 1'b0;
            o_de          <= 1'b0;
            o_ma          <= 14'd0;
            o_ra          <= 5'd0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            if (i_char_en) begin
                o_h_sync      <= w_hs_now;
                o_v_sync      <= w_vs_now;
                o_de          <= w_de_now;
                o_ma          <= r_ma_cnt;
                o_ra          <= (r_state == ST_ACTIVE) ? r_ra_cnt : r_adj;
                o_frame_start <= w_frame_start;

                r_hc <= w_line_end ? 8'd0 : (r_hc + 8'd1);

                if (w_hs_start) begin
                    r_hs_cnt <= i_sync_width[3:0] - 4'd1;
                end else if (r_hs_cnt != 4'd0) begin
                    r_hs_cnt <= r_hs_cnt - 4'd1;
                end

                // A start on a one-character line is also that line's end,
                // so the current line is already used up.
                if (w_vs_start) begin
                    r_vs_cnt <= w_line_end ? (w_vs_len - 5'd1) : w_vs_len;
                end else if (w_line_end && (r_vs_cnt != 5'd0)) begin
                    r_vs_cnt <= r_vs_cnt - 5'd1;
                end

                r_ma_cnt <= r_ma_cnt + 14'd1;

                if (w_line_end) begin
                    if (w_frame_start) begin
                        r_state  <= ST_ACTIVE;
                        r_vc     <= 7'd0;
                        r_ra_cnt <= 5'd0;
                        r_adj    <= 5'd0;
                        r_ma_row <= i_start_addr;
                        r_ma_cnt <= i_start_addr;
                    end else if (r_state == ST_ACTIVE) begin
                        if (!w_ra_last) begin
                            r_ra_cnt <= r_ra_cnt + 5'd1;
                            r_ma_cnt <= r_ma_row;
                        end else if (w_row_end) begin
                            r_ra_cnt <= 5'd0;
                            r_vc     <= r_vc + 7'd1;
                            r_ma_row <= w_ma_next_row;
                            r_ma_cnt <= w_ma_next_row;
                        end else if (w_enter_adjust) begin
                            r_ra_cnt <= 5'd0;
                            r_state  <= ST_ADJUST;
                            r_adj    <= 5'd0;
                            r_ma_cnt <= r_ma_row;
                        end else begin
                            r_ra_cnt <= 5'd0;
                            r_ma_cnt <= r_ma_row;
                        end
                    end else begin
                        r_adj    <= r_adj + 5'd1;
                        r_ma_cnt <= r_ma_row;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_crtc_timing.sv
// ---------------------------------------------------------------------------
// tb_crtc_timing
// Directed testbench for crtc_timing. Each character step is compared as one
// packed vector {frame_start, h_sync, v_sync, de, ra, ma} against values
// worked out from the frame geometry of the configuration under test.
// ---------------------------------------------------------------------------
module tb_crtc_timing;

    logic        clk = 1'b0;
    logic        reset;
    logic        charEn;
    logic [7:0]  hTotal, hDisplayed, hSyncPos, syncWidth;
    logic [6:0]  vTotal, vDisplayed, vSyncPos;
    logic [4:0]  vAdjust, maxScan;
    logic [13:0] startAddr;
    logic        hSync, vSync, de, frameStart;
    logic [13:0] ma;
    logic [4:0]  ra;

    int checks = 0;
    int errors = 0;

    crtc_timing dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_char_en     (charEn),
        .i_h_total     (hTotal),
        .i_h_displayed (hDisplayed),
        .i_h_sync_pos  (hSyncPos),
        .i_sync_width  (syncWidth),
        .i_v_total     (vTotal),
        .i_v_adjust    (vAdjust),
        .i_v_displayed (vDisplayed),
        .i_v_sync_pos  (vSyncPos),
        .i_max_scan    (maxScan),
        .i_start_addr  (startAddr),
        .o_h_sync      (hSync),
        .o_v_sync      (vSync),
        .o_de          (de),
        .o_ma          (ma),
        .o_ra          (ra),
        .o_frame_start (frameStart)
    );

    always #5 clk = ~clk;

    // Guard against any stall of the stimulus sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] dutVec();
        return {9'd0, frameStart, hSync, vSync, de, ra, ma};
    endfunction

    function automatic logic [31:0] pack(input bit fs, input bit hs, input bit vs, input bit den,
                                         input int raV, input int maV);
        logic [4:0]  r5;
        logic [13:0] m14;
        r5  = raV[4:0];
        m14 = maV[13:0];
        return {9'd0, fs, hs, vs, den, r5, m14};
    endfunction

    // PET geometry: 50 chars/line, 41 rows of 8 lines, 5 adjust lines.
    function automatic logic [31:0] petVec(input int p, input bit first, input int base);
        int  ln, hc, raV, maV;
        bit  fs, hs, vs, den;
        ln  = p / 50;
        hc  = p % 50;
        fs  = (p == 16649);
        hs  = (hc >= 41) || (hc <= 5 && !(first && ln == 0));
        vs  = (ln >= 264) && (ln <= 279);
        den = (hc < 40) && (ln < 200);
        raV = (ln < 328) ? (ln % 8) : (ln - 328);
        maV = (base + ((ln < 328) ? (ln / 8) * 40 : 1600) + hc) % 16384;
        return pack(fs, hs, vs, den, raV, maV);
    endfunction

    // Small geometry: 10 chars/line, 8 rows of 2 lines, 2 adjust lines.
    // wideSync=0: R3=0x00 (no HSYNC, 16-line VSYNC); wideSync=1: R3=0x3F.
    function automatic logic [31:0] smallVec(input int p, input bit wideSync, input int base2);
        int  f, q, ln, hc, g, raV, maV;
        bit  fs, hs, vs, den;
        f   = p / 180;
        q   = p % 180;
        ln  = q / 10;
        hc  = q % 10;
        g   = p / 10;
        fs  = (q == 179);
        if (wideSync) begin
            hs = !((p < 6) || ((g % 2 == 0) && hc >= 1 && hc <= 5));
            vs = (ln >= 2) && (ln <= 4);
        end else begin
            hs = 1'b0;
            vs = (g >= 2 && g <= 17) || (g >= 20 && g <= 35);
        end
        den = (hc < 4) && (ln < 4);
        raV = (ln < 16) ? (ln % 2) : (ln - 16);
        maV = (((f == 0) ? 0 : base2) + ((ln < 16) ? (ln / 2) * 4 : 28) + hc) % 16384;
        return pack(fs, hs, vs, den, raV, maV);
    endfunction

    // Degenerate geometry: R1=0, R5=0, R2>R0, R7>R4; 4 rows of 2 lines.
    function automatic logic [31:0] degVec(input int p);
        int q;
        q = p % 80;
        return pack(q == 79, 1'b0, 1'b0, 1'b0, (q / 10) % 2, q % 10);
    endfunction

    // One character step; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus();
        charEn = 1'b1;
        @(posedge clk);
        #1;
        charEn = 1'b0;
    endtask

    task automatic idleClock();
        charEn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        charEn = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic setPet();
        hTotal = 8'h31; hDisplayed = 8'h28; hSyncPos = 8'h29; syncWidth = 8'h0F;
        vTotal = 7'h28; vAdjust = 5'd5; vDisplayed = 7'h19; vSyncPos = 7'h21;
        maxScan = 5'd7;
    endtask

    task automatic setSmall(input logic [7:0] width, input logic [13:0] start);
        hTotal = 8'd9; hDisplayed = 8'd4; hSyncPos = 8'd6; syncWidth = width;
        vTotal = 7'd7; vAdjust = 5'd2; vDisplayed = 7'd2; vSyncPos = 7'd1;
        maxScan = 5'd1; startAddr = start;
    endtask

    task automatic runPet(input string name, input int n, input bit first, input int base);
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            checkOutput($sformatf("%s p%0d", name, i), dutVec(), petVec(i, first, base));
        end
    endtask

    task automatic runSmall(input string name, input bit wideSync, input int base2);
        for (int i = 0; i < 360; i++) begin
            applyStimulus();
            checkOutput($sformatf("%s p%0d", name, i), dutVec(), smallVec(i, wideSync, base2));
        end
    endtask

    initial begin
        logic [31:0] expv;
        charEn = 1'b0;
        reset  = 1'b1;
        setPet();
        startAddr = 14'h0100;

        // Reset state, while held and after release with no char_en.
        #1;
        checkOutput("reset held", dutVec(), 32'd0);
        doReset();
        idleClock();
        checkOutput("reset released idle", dutVec(), 32'd0);

        // Frame after reset starts from MA 0; next frame picks up 0x0100.
        runPet("pet frameA", 16650, 1'b1, 0);
        runPet("pet frameB", 13510, 1'b0, 16'h0100);

        // Asynchronous reset in the middle of VSYNC, line 270.
        reset = 1'b1;
        #1;
        checkOutput("async reset", dutVec(), 32'd0);
        charEn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset holds", dutVec(), 32'd0);
        charEn = 1'b0;
        reset  = 1'b0;
        runPet("pet after reset", 16650, 1'b1, 0);

        // R0 lowered from 0x31 to 0x10 while hc = 0x20.
        doReset();
        setPet();
        runPet("pet pre-R0", 32, 1'b1, 0);
        hTotal = 8'h10;
        applyStimulus();
        checkOutput("R0 low hc20", {17'd0, ra, ma}, {17'd0, 5'd0, 14'h0020});
        applyStimulus();
        checkOutput("R0 low wrap", {17'd0, ra, ma}, {17'd0, 5'd1, 14'h0000});
        for (int i = 0; i < 16; i++) applyStimulus();
        checkOutput("R0 low line end", {17'd0, ra, ma}, {17'd0, 5'd1, 14'h0010});
        applyStimulus();
        checkOutput("R0 low next line", {17'd0, ra, ma}, {17'd0, 5'd2, 14'h0000});

        // Sync width field extremes and 14-bit MA wrap.
        doReset();
        setSmall(8'h00, 14'h0000);
        runSmall("r3=00", 1'b0, 0);
        doReset();
        setSmall(8'h3F, 14'h3FF0);
        runSmall("r3=3f", 1'b1, 16'h3FF0);

        // Degenerate registers with idle clocks between character steps.
        doReset();
        hTotal = 8'd9; hDisplayed = 8'd0; hSyncPos = 8'd12; syncWidth = 8'h11;
        vTotal = 7'd3; vAdjust = 5'd0; vDisplayed = 7'd2; vSyncPos = 7'd5;
        maxScan = 5'd1; startAddr = 14'h0000;
        for (int i = 0; i < 160; i++) begin
            applyStimulus();
            expv = degVec(i);
            checkOutput($sformatf("degenerate p%0d", i), dutVec(), expv);
            idleClock();
            expv[22] = 1'b0;
            checkOutput($sformatf("degenerate idle p%0d", i), dutVec(), expv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
